// File: rtl/pred_pkg.sv
// Shared types for the branch predictor table: controller FSM states,
// 2-bit counter encodings and saturating counter helpers.
package pred_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } pred_state_e;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == ST) ? ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == SNT) ? SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/predictor_table_ctrl_if.sv
// Fetch lookup port and execute update port of the predictor table.
// Handshake: a transfer happens on a posedge where valid && ready are both 1;
// ready never depends combinationally on valid, and a producer holds valid and
// its payload stable until the transfer occurs.
interface predictor_table_ctrl_if #(
  parameter int IDX_W = 4
);
  logic             req_valid;
  logic [IDX_W-1:0] req_idx;
  logic             req_ready;
  logic             pred_valid;
  logic [IDX_W-1:0] pred_idx;
  logic             pred_taken;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             upd_ready;
  logic             init_busy;

  modport master (
    output req_valid, req_idx, upd_valid, upd_idx, upd_taken,
    input  req_ready, pred_valid, pred_idx, pred_taken, upd_ready, init_busy
  );

  modport slave (
    input  req_valid, req_idx, upd_valid, upd_idx, upd_taken,
    output req_ready, pred_valid, pred_idx, pred_taken, upd_ready, init_busy
  );
endinterface

// File: rtl/pred_upd_fifo.sv
// Synchronous FIFO holding resolved-branch updates {idx, taken}; rst flushes
// every queued entry. Push when full and pop when empty are ignored.
module pred_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/predictor_table_ctrl.sv
// 2-bit saturating branch predictor table with init sweep, buffered updates and
// a one-access-per-cycle arbiter. Optional PRED_STATS_EN adds lookup/mispredict counters.
module predictor_table_ctrl
  import pred_pkg::*;
#(
  parameter int         IDX_W      = 4,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [1:0] INIT_STATE = 2'd3
) (
  input  logic                          clk,
  input  logic                          rst,
  predictor_table_ctrl_if.slave         bus,
  output pred_state_e                   fsm_state,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef PRED_STATS_EN
  ,
  output logic [15:0]                   lookup_cnt,
  output logic [15:0]                   mispred_cnt
`endif
);
  localparam int ENT_W = IDX_W + 1;

  pred_state_e      state_q, state_d;
  logic [IDX_W-1:0] init_ptr;
  logic [1:0]       cnt_mem [1<<IDX_W];

  logic             fifo_full, fifo_empty;
  logic             push, lookup, drain;
  logic             req_ready, upd_ready, init_busy;
  logic [ENT_W-1:0] head;
  logic [IDX_W-1:0] head_idx;
  logic             head_taken;
  logic [1:0]       head_cnt;

  assign head_idx   = head[IDX_W:1];
  assign head_taken = head[0];
  assign head_cnt   = cnt_mem[head_idx];
  assign push       = bus.upd_valid && upd_ready;
  assign fsm_state  = state_q;

  assign bus.req_ready = req_ready;
  assign bus.upd_ready = upd_ready;
  assign bus.init_busy = init_busy;

  // Full FIFO wins the table port; otherwise lookups win and updates use idle slots.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    upd_ready = 1'b0;
    init_busy = 1'b0;
    lookup    = 1'b0;
    drain     = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_busy = 1'b1;
        if (&init_ptr) state_d = ST_RUN;
      end
      ST_RUN: begin
        upd_ready = !fifo_full;
        if (fifo_full) begin
          drain = 1'b1;
        end else begin
          req_ready = 1'b1;
          lookup    = bus.req_valid;
          drain     = !bus.req_valid && !fifo_empty;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_INIT;
      init_ptr <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) init_ptr <= init_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_INIT)
        cnt_mem[init_ptr] <= INIT_STATE;
      else if (drain)
        cnt_mem[head_idx] <= head_taken ? sat_inc(head_cnt) : sat_dec(head_cnt);
    end
  end

  // Lookups see only drained state; queued updates are not forwarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.pred_valid <= 1'b0;
      bus.pred_idx   <= '0;
      bus.pred_taken <= 1'b0;
    end else begin
      bus.pred_valid <= lookup;
      if (lookup) begin
        bus.pred_idx   <= bus.req_idx;
        bus.pred_taken <= cnt_mem[bus.req_idx][1];
      end
    end
  end

  pred_upd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({bus.upd_idx, bus.upd_taken}),
    .pop       (drain),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_level)
  );

`ifdef PRED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lookup_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (lookup && lookup_cnt != 16'hFFFF)
        lookup_cnt <= lookup_cnt + 16'd1;
      if (drain && (head_taken != head_cnt[1]) && mispred_cnt != 16'hFFFF)
        mispred_cnt <= mispred_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_predictor_table_ctrl.sv
// Directed bench for predictor_table_ctrl: init sweep, counter saturation,
// full-FIFO arbitration, stale lookups, mid-run reset and optional stats.
module tb_predictor_table_ctrl;
  import pred_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  predictor_table_ctrl_if #(.IDX_W(4)) bus ();
  pred_state_e fsm_state;
  logic [2:0]  fifo_level;
`ifdef PRED_STATS_EN
  logic [15:0] lookup_cnt;
  logic [15:0] mispred_cnt;
`endif

  predictor_table_ctrl #(
    .IDX_W      (4),
    .FIFO_DEPTH (4),
    .INIT_STATE (2'd3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .fsm_state   (fsm_state),
    .fifo_level  (fifo_level)
`ifdef PRED_STATS_EN
    ,
    .lookup_cnt  (lookup_cnt),
    .mispred_cnt (mispred_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [4:0] exp_q[$];
  logic [4:0] sb_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic lookup(input logic [3:0] idx, input logic exp_taken);
    int waited = 0;
    bus.req_valid = 1'b1;
    bus.req_idx   = idx;
    while (!bus.req_ready && waited < 10) begin
      tick();
      waited++;
    end
    if (!bus.req_ready) check("lookup_wait", bus.req_ready, 1'b1);
    exp_q.push_back({idx, exp_taken});
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic push_upd(input logic [3:0] idx, input logic taken);
    int waited = 0;
    bus.upd_valid = 1'b1;
    bus.upd_idx   = idx;
    bus.upd_taken = taken;
    while (!bus.upd_ready && waited < 10) begin
      tick();
      waited++;
    end
    if (!bus.upd_ready) check("upd_wait", bus.upd_ready, 1'b1);
    tick();
    bus.upd_valid = 1'b0;
  endtask

  task automatic wait_init();
    int busy = 0;
    logic rr = 1'b0;
    while (bus.init_busy && busy < 40) begin
      rr |= bus.req_ready;
      busy++;
      tick();
    end
    check("init_cycles", busy, 16);
    check("init_req_ready", rr, 1'b0);
    check("run_state", fsm_state, ST_RUN);
    check("run_req_ready", bus.req_ready, 1'b1);
  endtask

  // Scoreboard: every prediction pulse must match the oldest expected {idx, taken}.
  always @(posedge clk) begin
    #1;
    if (bus.pred_valid) begin
      if (exp_q.size() == 0) begin
        check("pred_unexpected", bus.pred_valid, 1'b0);
      end else begin
        sb_exp = exp_q.pop_front();
        check("pred_idx", bus.pred_idx, sb_exp[4:1]);
        check("pred_taken", bus.pred_taken, sb_exp[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit [6:0] exp_rdy;
    bit [4:0] taken_seq;
    int sent;

    bus.req_valid = 1'b0;
    bus.req_idx   = '0;
    bus.upd_valid = 1'b0;
    bus.upd_idx   = '0;
    bus.upd_taken = 1'b0;

    // Reset values
    rst = 1'b1;
    idle(3);
    check("rst_req_ready", bus.req_ready, 1'b0);
    check("rst_pred_valid", bus.pred_valid, 1'b0);
    check("rst_pred_idx", bus.pred_idx, 4'd0);
    check("rst_pred_taken", bus.pred_taken, 1'b0);
    check("rst_upd_ready", bus.upd_ready, 1'b0);
    check("rst_init_busy", bus.init_busy, 1'b1);
    check("rst_state", fsm_state, ST_INIT);
    rst = 1'b0;
    wait_init();

    // Every entry starts strongly taken
    for (int i = 0; i < 16; i++) lookup(4'(i), 1'b1);

    // Idx 5 saturation down then back up
    repeat (4) push_upd(4'd5, 1'b0);
    idle(4);
    lookup(4'd5, 1'b0);
    push_upd(4'd5, 1'b0);
    idle(2);
    lookup(4'd5, 1'b0);
    push_upd(4'd5, 1'b1);
    idle(2);
    lookup(4'd5, 1'b0);
    push_upd(4'd5, 1'b1);
    idle(2);
    lookup(4'd5, 1'b1);

    // Continuous lookups with 5 back-to-back updates to idx 8 (order-sensitive pattern)
    exp_rdy   = 7'b0101111;
    taken_seq = 5'b11000;
    sent      = 0;
    bus.req_valid = 1'b1;
    bus.req_idx   = 4'd7;
    for (int c = 0; c < 7; c++) begin
      bus.upd_valid = (sent < 5);
      bus.upd_idx   = 4'd8;
      bus.upd_taken = (sent < 5) ? taken_seq[sent] : 1'b0;
      check($sformatf("full_upd_ready_c%0d", c), bus.upd_ready, exp_rdy[c]);
      check($sformatf("full_req_ready_c%0d", c), bus.req_ready, exp_rdy[c]);
      if (bus.upd_valid && bus.upd_ready) sent++;
      if (bus.req_ready) exp_q.push_back({4'd7, 1'b1});
      tick();
    end
    bus.req_valid = 1'b0;
    bus.upd_valid = 1'b0;
    check("full_upd_accepted", sent, 5);
    idle(5);
    check("full_drained_level", fifo_level, 3'd0);
    check("full_drained_upd_ready", bus.upd_ready, 1'b1);
    lookup(4'd8, 1'b1);

    // Same-cycle lookup and update of idx 3 (state 2): lookup sees stale value
    push_upd(4'd3, 1'b0);
    idle(2);
    bus.req_valid = 1'b1;
    bus.req_idx   = 4'd3;
    bus.upd_valid = 1'b1;
    bus.upd_idx   = 4'd3;
    bus.upd_taken = 1'b0;
    check("same_req_ready", bus.req_ready, 1'b1);
    check("same_upd_ready", bus.upd_ready, 1'b1);
    exp_q.push_back({4'd3, 1'b1});
    tick();
    bus.req_valid = 1'b0;
    bus.upd_valid = 1'b0;
    tick();
    lookup(4'd3, 1'b0);

    // Reset with three updates queued behind continuous lookups
    bus.req_valid = 1'b1;
    bus.req_idx   = 4'd0;
    bus.upd_valid = 1'b1;
    bus.upd_idx   = 4'd1;
    bus.upd_taken = 1'b0;
    repeat (3) begin
      exp_q.push_back({4'd0, 1'b1});
      tick();
    end
    check("queued_level", fifo_level, 3'd3);
    bus.req_valid = 1'b0;
    bus.upd_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("midrst_pred_valid", bus.pred_valid, 1'b0);
    check("midrst_level", fifo_level, 3'd0);
    check("midrst_upd_ready", bus.upd_ready, 1'b0);
    check("midrst_init_busy", bus.init_busy, 1'b1);
    check("midrst_state", fsm_state, ST_INIT);
    rst = 1'b0;
    wait_init();
    idle(4);
    check("reinit_level", fifo_level, 3'd0);
    for (int i = 0; i < 16; i++) lookup(4'(i), 1'b1);

`ifdef PRED_STATS_EN
    rst = 1'b1;
    idle(2);
    check("stats_rst_lookup", lookup_cnt, 16'd0);
    check("stats_rst_mispred", mispred_cnt, 16'd0);
    rst = 1'b0;
    wait_init();
    check("stats_init_lookup", lookup_cnt, 16'd0);
    for (int i = 0; i < 10; i++) lookup(4'(i), 1'b1);
    push_upd(4'd9, 1'b0);
    push_upd(4'd9, 1'b0);
    push_upd(4'd10, 1'b0);
    idle(4);
    check("stats_lookup", lookup_cnt, 16'd10);
    check("stats_mispred", mispred_cnt, 16'd3);
`endif

    idle(2);
    check("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
